// File: rtl/alu_pipe_if.sv
// Handshaked operand/result bundle for alu_pipe.
// The master drives operands and out_ready; the slave (the ALU) drives in_ready and the registered result.
interface alu_pipe_if #(
  parameter int unsigned DATA_WIDTH = 32
);

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] A;
  logic [DATA_WIDTH-1:0] B;
  logic [3:0]            ALUop;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] Result;
  logic                  Overflow;
  logic                  CarryOut;
  logic                  Zero;

  modport master (
    output in_valid, A, B, ALUop, out_ready,
    input  in_ready, out_valid, Result, Overflow, CarryOut, Zero
  );

  modport slave (
    input  in_valid, A, B, ALUop, out_ready,
    output in_ready, out_valid, Result, Overflow, CarryOut, Zero
  );

endinterface

// File: rtl/alu_pipe.sv
// Parametrised ALU with a registered single-entry result buffer behind valid/ready.
// Single-cycle ops take one cycle; MULU runs a W-cycle shift-add sequence.
module alu_pipe #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter bit          MUL_EN     = 1'b1
) (
  input  logic       clk,
  input  logic       resetn,
  alu_pipe_if.slave  bus
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned HW = DATA_WIDTH / 2;
  localparam int unsigned SW = $clog2(DATA_WIDTH);
  localparam int unsigned CW = $clog2(DATA_WIDTH);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] MUL  = 1'b1;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_LUI  = 4'b0011;
  localparam logic [3:0] OP_SLTU = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_XOR  = 4'b1000;
  localparam logic [3:0] OP_NOR  = 4'b1001;
  localparam logic [3:0] OP_SLL  = 4'b1010;
  localparam logic [3:0] OP_SRL  = 4'b1011;
  localparam logic [3:0] OP_SRA  = 4'b1100;
  localparam logic [3:0] OP_MULU = 4'b1101;

  logic [0:0]    state_q,     state_d;
  logic [W-1:0]  mcand_q,     mcand_d;
  logic [W-1:0]  mplier_q,    mplier_d;
  logic [W-1:0]  acc_q,       acc_d;
  logic [CW-1:0] cnt_q,       cnt_d;
  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  result_q,    result_d;
  logic          ovf_q,       ovf_d;
  logic          carry_q,     carry_d;
  logic          zero_q,      zero_d;

  logic [W:0]    sum_c;
  logic [W:0]    diff_c;
  logic [SW-1:0] sh_c;
  logic [W-1:0]  alu_res_c;
  logic          alu_ovf_c;
  logic          alu_carry_c;
  logic          is_mul_c;
  logic [W-1:0]  acc_step_c;
  logic          in_ready_c;
  logic          accept_c;
  logic          retire_c;

  // Single-cycle operations; MULU is produced by the FSM, undefined ops give zero.
  always_comb begin
    sh_c        = bus.B[SW-1:0];
    sum_c       = {1'b0, bus.A} + {1'b0, bus.B};
    diff_c      = {1'b0, bus.A} - {1'b0, bus.B};
    alu_res_c   = '0;
    alu_ovf_c   = 1'b0;
    alu_carry_c = 1'b0;
    case (bus.ALUop)
      OP_AND:  alu_res_c = bus.A & bus.B;
      OP_OR:   alu_res_c = bus.A | bus.B;
      OP_ADD: begin
        alu_res_c   = sum_c[W-1:0];
        alu_carry_c = sum_c[W];
        alu_ovf_c   = (bus.A[W-1] == bus.B[W-1]) && (sum_c[W-1] != bus.A[W-1]);
      end
      OP_LUI:  alu_res_c = {bus.B[HW-1:0], {HW{1'b0}}};
      OP_SLTU: alu_res_c[0] = bus.A < bus.B;
      OP_SUB: begin
        alu_res_c   = diff_c[W-1:0];
        alu_carry_c = diff_c[W];
        alu_ovf_c   = (bus.A[W-1] != bus.B[W-1]) && (diff_c[W-1] != bus.A[W-1]);
      end
      OP_SLT:  alu_res_c[0] = $signed(bus.A) < $signed(bus.B);
      OP_XOR:  alu_res_c = bus.A ^ bus.B;
      OP_NOR:  alu_res_c = ~(bus.A | bus.B);
      OP_SLL:  alu_res_c = bus.A << sh_c;
      OP_SRL:  alu_res_c = bus.A >> sh_c;
      OP_SRA:  alu_res_c = W'($signed(bus.A) >>> sh_c);
      default: alu_res_c = '0;
    endcase
  end

  assign is_mul_c   = MUL_EN && (bus.ALUop == OP_MULU);
  assign acc_step_c = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  // Accept only in IDLE with a free (or simultaneously retiring) output slot.
  assign in_ready_c = resetn && (state_q == IDLE) && (!out_valid_q || bus.out_ready);
  assign accept_c   = bus.in_valid && in_ready_c;
  assign retire_c   = out_valid_q && bus.out_ready;

  // Next-state and output-register logic.
  always_comb begin
    state_d     = state_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    ovf_d       = ovf_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    case (state_q)
      IDLE: begin
        if (retire_c) begin
          out_valid_d = 1'b0;
        end
        if (accept_c) begin
          if (is_mul_c) begin
            mcand_d  = bus.A;
            mplier_d = bus.B;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = MUL;
          end else begin
            result_d    = alu_res_c;
            ovf_d       = alu_ovf_c;
            carry_d     = alu_carry_c;
            zero_d      = (alu_res_c == '0);
            out_valid_d = 1'b1;
          end
        end
      end
      MUL: begin
        acc_d    = acc_step_c;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = CW'(cnt_q + 1'b1);
        // Last partial product: publish the low W bits and go back to IDLE.
        if (cnt_q == CW'(W - 1)) begin
          result_d    = acc_step_c;
          ovf_d       = 1'b0;
          carry_d     = 1'b0;
          zero_d      = (acc_step_c == '0);
          out_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      ovf_q       <= ovf_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.Result    = result_q;
  assign bus.Overflow  = ovf_q;
  assign bus.CarryOut  = carry_q;
  assign bus.Zero      = zero_q;

endmodule
